// File: rtl/mesi_pkg.sv
// Shared MESI bus definitions: bus transaction codes, processor ops, responder states
// and the bit layout of a request/response word {pid, trans_id, tag, index, data}.
package mesi_pkg;

    typedef enum logic [2:0] {
        TR_NONE     = 3'd0,
        TR_BUS_RD   = 3'd1,
        TR_BUS_RDX  = 3'd2,
        TR_BUS_UPGR = 3'd3,
        TR_FLUSH    = 3'd4,
        TR_DATA_E   = 3'd5,
        TR_DATA_S   = 3'd6,
        TR_ACK      = 3'd7
    } bus_trans_t;

    typedef enum logic [1:0] {
        PR_NONE = 2'd0,
        PR_RD   = 2'd1,
        PR_WR   = 2'd2
    } pr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SNOOP = 2'd2,
        ST_RESP  = 2'd3
    } resp_state_t;

    localparam int PID_W = 2;
    localparam int TID_W = 3;
    localparam int TAG_W = 2;
    localparam int IDX_W = 2;
    localparam int HDR_W = PID_W + TID_W + TAG_W + IDX_W;

    // Field offsets measured from the top of the data field
    localparam int IDX_OFF = 0;
    localparam int TAG_OFF = IDX_OFF + IDX_W;
    localparam int TID_OFF = TAG_OFF + TAG_W;
    localparam int PID_OFF = TID_OFF + TID_W;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    int j;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        // Scan from the far end so the nearest requester is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                idx_o   = PTR_W'(j);
                valid_o = 1'b1;
            end
        end
        grant_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mesi_mem_responder.sv
// Memory side of the MESI snooping bus: arbitrates core requests, serves reads from the
// backing store unless a peer flushes the line, absorbs writebacks, reports sharing.
module mesi_mem_responder
    import mesi_pkg::*;
#(
    parameter int                        Cache_Block_Size = 8,
    parameter int                        N_CORES          = 4,
    parameter int                        SNOOP_CYC        = 2,
    parameter logic [Cache_Block_Size-1:0] MEM_INIT       = 8'hff
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [N_CORES*(HDR_W+Cache_Block_Size)-1:0]   req_bus,
    input  logic [N_CORES-1:0]                            req_flag,
    input  logic [N_CORES-1:0]                            snoop_hit,
    output logic [N_CORES-1:0]                            grant,
    output logic [HDR_W+Cache_Block_Size-1:0]             resp_bus,
    output logic                                          resp_flag,
    output logic                                          busy
);

    localparam int BW      = HDR_W + Cache_Block_Size;
    localparam int AW      = TAG_W + IDX_W;
    localparam int DEPTH   = 1 << AW;
    localparam int IDX_LSB = Cache_Block_Size + IDX_OFF;
    localparam int TID_LSB = Cache_Block_Size + TID_OFF;
    localparam int PID_LSB = Cache_Block_Size + PID_OFF;
    localparam int PTR_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    resp_state_t                 state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [PTR_W-1:0]            gidx_q, gidx_d;
    logic [N_CORES-1:0]          grant_q, grant_d;
    logic [BW-1:0]               req_q, req_d;
    logic [Cache_Block_Size-1:0] rdata_q, rdata_d;
    logic                        sharer_q, sharer_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [BW-1:0]               resp_bus_q, resp_bus_d;
    logic                        resp_flag_q, resp_flag_d;
    logic [Cache_Block_Size-1:0] mem_q [DEPTH];

    logic                        mem_we;
    logic [AW-1:0]               mem_waddr;
    logic [Cache_Block_Size-1:0] mem_wdata;
    logic [BW-1:0]               req_w [N_CORES];
    logic [N_CORES-1:0]          arb_grant;
    logic [PTR_W-1:0]            arb_idx;
    logic                        arb_valid;
    logic                        fl_hit;
    logic [Cache_Block_Size-1:0] fl_data;
    bus_trans_t                  req_tid;
    bus_trans_t                  resp_id;
    logic [AW-1:0]               req_addr;
    logic [PID_W-1:0]            req_pid;
    logic [Cache_Block_Size-1:0] req_data;

    always_comb begin
        for (int k = 0; k < N_CORES; k++) begin
            req_w[k] = req_bus[k*BW +: BW];
        end
    end

    assign req_tid  = bus_trans_t'(req_q[TID_LSB +: TID_W]);
    assign req_addr = req_q[IDX_LSB +: AW];
    assign req_pid  = req_q[PID_LSB +: PID_W];
    assign req_data = req_q[Cache_Block_Size-1:0];

    rr_arbiter #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_flag),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // A peer writing back the line being read supplies it; lowest index wins
    always_comb begin
        fl_hit  = 1'b0;
        fl_data = '0;
        for (int j = N_CORES - 1; j >= 0; j--) begin
            if (!grant_q[j] && req_flag[j]
                && req_w[j][TID_LSB +: TID_W] == TR_FLUSH
                && req_w[j][IDX_LSB +: AW] == req_addr) begin
                fl_hit  = 1'b1;
                fl_data = req_w[j][Cache_Block_Size-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        sharer_d    = sharer_q;
        cnt_d       = cnt_q;
        resp_bus_d  = resp_bus_q;
        resp_flag_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_data;
        resp_id     = TR_DATA_E;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    req_d   = req_w[arb_idx];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                case (req_tid)
                    TR_FLUSH, TR_BUS_UPGR: begin
                        mem_we      = (req_tid == TR_FLUSH);
                        resp_bus_d  = {req_pid, TR_ACK, req_addr, req_data};
                        resp_flag_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                    TR_BUS_RD, TR_BUS_RDX: begin
                        sharer_d = 1'b0;
                        cnt_d    = '0;
                        rdata_d  = mem_q[req_addr];
                        state_d  = ST_SNOOP;
                    end
                    default: begin
                        grant_d = '0;
                        ptr_d   = (gidx_q == PTR_W'(N_CORES - 1)) ? '0 : gidx_q + 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_SNOOP: begin
                sharer_d = sharer_q | (|(snoop_hit & ~grant_q));
                if (fl_hit) begin
                    mem_we    = 1'b1;
                    mem_wdata = fl_data;
                    rdata_d   = fl_data;
                    sharer_d  = 1'b1;
                end
                if (cnt_q == 3'(SNOOP_CYC - 1)) begin
                    resp_id     = (req_tid == TR_BUS_RD && sharer_d) ? TR_DATA_S : TR_DATA_E;
                    resp_bus_d  = {req_pid, resp_id, req_addr, rdata_d};
                    resp_flag_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                ptr_d   = (gidx_q == PTR_W'(N_CORES - 1)) ? '0 : gidx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            sharer_q    <= 1'b0;
            cnt_q       <= '0;
            resp_bus_q  <= '0;
            resp_flag_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= MEM_INIT;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            sharer_q    <= sharer_d;
            cnt_q       <= cnt_d;
            resp_bus_q  <= resp_bus_d;
            resp_flag_q <= resp_flag_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        req_q   <= req_d;
        rdata_q <= rdata_d;
    end

    assign grant     = grant_q;
    assign resp_bus  = resp_bus_q;
    assign resp_flag = resp_flag_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mesi_mem_responder.sv
// Directed bench for mesi_mem_responder: reads, writebacks, sharing, snoop-time flush,
// round-robin bursts and mid-transaction reset, with hand-computed response words.
module tb_mesi_mem_responder;

    localparam logic [2:0] T_NONE = 3'd0, T_RD = 3'd1, T_RDX = 3'd2, T_UPGR = 3'd3,
                           T_FL = 3'd4, T_DE = 3'd5, T_DS = 3'd6, T_ACK = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [67:0] req_bus = '0;
    logic [3:0]  req_flag = '0;
    logic [3:0]  snoop_hit = '0;
    logic [3:0]  grant;
    logic [16:0] resp_bus;
    logic        resp_flag;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    mesi_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_bus   (req_bus),
        .req_flag  (req_flag),
        .snoop_hit (snoop_hit),
        .grant     (grant),
        .resp_bus  (resp_bus),
        .resp_flag (resp_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input int pid, input logic [2:0] tid,
                                       input logic [3:0] addr, input logic [7:0] data);
        logic [1:0] p;
        p = 2'(pid);
        return {p, tid, addr, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int core, input logic [2:0] tid, input logic [3:0] addr,
                        input logic [7:0] data);
        req_bus[core*17 +: 17] = mk(core, tid, addr, data);
        req_flag[core] = 1'b1;
    endtask

    task automatic run_txn(input int core, input logic [2:0] tid, input logic [3:0] addr,
                           input logic [7:0] data, output int lat, output logic [16:0] rb);
        lat = -1;
        rb  = '0;
        post(core, tid, addr, data);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (resp_flag === 1'b1) begin
                lat = c;
                rb  = resp_bus;
                break;
            end
        end
        req_flag[core] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (grant !== 4'b0) $display("FAIL reset_grant got %h want 0", grant); else pass_cnt++;
        total_cnt++; if (resp_flag !== 1'b0) $display("FAIL reset_resp_flag got %b want 0", resp_flag); else pass_cnt++;
        total_cnt++; if (resp_bus !== 17'h0) $display("FAIL reset_resp_bus got %h want 0", resp_bus); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_rd();
        int lat; logic [16:0] rb;
        post(0, T_RD, 4'h0, 8'h00);
        tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL rd_grant got %b want 0001", grant); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rd_busy got %b want 1", busy); else pass_cnt++;
        req_flag[0] = 1'b0;
        tick(); tick();
        total_cnt++; if (resp_flag !== 1'b0) $display("FAIL rd_early got %b want 0", resp_flag); else pass_cnt++;
        tick();
        total_cnt++; if (resp_flag !== 1'b1) $display("FAIL rd_lat4 got %b want 1", resp_flag); else pass_cnt++;
        total_cnt++; if (resp_bus !== mk(0, T_DE, 4'h0, 8'hff)) $display("FAIL rd_word got %h want %h", resp_bus, mk(0, T_DE, 4'h0, 8'hff)); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0 || resp_flag !== 1'b0 || grant !== 4'b0) $display("FAIL rd_done busy=%b flag=%b grant=%b want 0,0,0", busy, resp_flag, grant); else pass_cnt++;
        lat = 0; rb = '0;
    endtask

    task automatic test_flush_then_rd();
        int lat; logic [16:0] rb;
        run_txn(2, T_FL, 4'h4, 8'd10, lat, rb);
        total_cnt++; if (lat != 2) $display("FAIL flush_lat got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rb !== mk(2, T_ACK, 4'h4, 8'd10)) $display("FAIL flush_ack got %h want %h", rb, mk(2, T_ACK, 4'h4, 8'd10)); else pass_cnt++;
        tick();
        run_txn(1, T_RD, 4'h4, 8'h00, lat, rb);
        total_cnt++; if (lat != 4) $display("FAIL rd_after_flush_lat got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rb !== mk(1, T_DE, 4'h4, 8'd10)) $display("FAIL rd_after_flush got %h want %h", rb, mk(1, T_DE, 4'h4, 8'd10)); else pass_cnt++;
        tick();
        run_txn(3, T_UPGR, 4'h9, 8'h00, lat, rb);
        total_cnt++; if (lat != 2 || rb !== mk(3, T_ACK, 4'h9, 8'h00)) $display("FAIL upgr got lat %0d %h want 2 %h", lat, rb, mk(3, T_ACK, 4'h9, 8'h00)); else pass_cnt++;
        tick();
    endtask

    task automatic test_shared();
        int lat; logic [16:0] rb;
        snoop_hit = 4'b0100;
        run_txn(1, T_RD, 4'h4, 8'h00, lat, rb);
        total_cnt++; if (rb !== mk(1, T_DS, 4'h4, 8'd10)) $display("FAIL rd_shared got %h want %h", rb, mk(1, T_DS, 4'h4, 8'd10)); else pass_cnt++;
        tick();
        run_txn(1, T_RDX, 4'h4, 8'h00, lat, rb);
        total_cnt++; if (rb !== mk(1, T_DE, 4'h4, 8'd10)) $display("FAIL rdx_excl got %h want %h", rb, mk(1, T_DE, 4'h4, 8'd10)); else pass_cnt++;
        tick();
        snoop_hit = 4'b0010;
        run_txn(1, T_RD, 4'h4, 8'h00, lat, rb);
        total_cnt++; if (rb !== mk(1, T_DE, 4'h4, 8'd10)) $display("FAIL rd_own_hit got %h want %h", rb, mk(1, T_DE, 4'h4, 8'd10)); else pass_cnt++;
        snoop_hit = 4'b0000;
        tick();
    endtask

    task automatic test_snoop_flush();
        int lat; logic [16:0] rb;
        post(0, T_RD, 4'h4, 8'h00);
        tick(); tick();
        post(3, T_FL, 4'h4, 8'd30);
        tick();
        total_cnt++; if (resp_flag !== 1'b0) $display("FAIL sf_early got %b want 0", resp_flag); else pass_cnt++;
        tick();
        total_cnt++; if (resp_flag !== 1'b1) $display("FAIL sf_resp_flag got %b want 1", resp_flag); else pass_cnt++;
        total_cnt++; if (resp_bus !== mk(0, T_DS, 4'h4, 8'd30)) $display("FAIL sf_word got %h want %h", resp_bus, mk(0, T_DS, 4'h4, 8'd30)); else pass_cnt++;
        req_flag[0] = 1'b0;
        lat = -1; rb = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (resp_flag === 1'b1) begin lat = c; rb = resp_bus; break; end
        end
        req_flag[3] = 1'b0;
        total_cnt++; if (rb !== mk(3, T_ACK, 4'h4, 8'd30)) $display("FAIL sf_flush_ack got %h want %h", rb, mk(3, T_ACK, 4'h4, 8'd30)); else pass_cnt++;
        tick();
        run_txn(2, T_RD, 4'h4, 8'h00, lat, rb);
        total_cnt++; if (rb !== mk(2, T_DE, 4'h4, 8'd30)) $display("FAIL sf_mem4 got %h want %h", rb, mk(2, T_DE, 4'h4, 8'd30)); else pass_cnt++;
        tick();
    endtask

    task automatic burst(input logic [16:0] exp_w [4], input string tag);
        int n; int pid; logic prev; int adj;
        logic [1:0] order [4]; logic [16:0] words [4];
        n = 0; prev = 1'b0; adj = 0;
        for (int k = 0; k < 4; k++) begin order[k] = '0; words[k] = '0; end
        for (int c = 0; c < 80 && n < 4; c++) begin
            tick();
            if (resp_flag === 1'b1) begin
                if (prev) adj++;
                pid = int'(resp_bus[16:15]);
                order[n] = resp_bus[16:15];
                words[n] = resp_bus;
                n++;
                req_flag[pid] = 1'b0;
            end
            prev = (resp_flag === 1'b1);
        end
        req_flag = '0;
        total_cnt++; if (n != 4) $display("FAIL %s_count got %0d want 4", tag, n); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (order[k] !== 2'(k)) $display("FAIL %s_order[%0d] got %0d want %0d", tag, k, order[k], k); else pass_cnt++;
            total_cnt++;
            if (words[k] !== exp_w[k]) $display("FAIL %s_word[%0d] got %h want %h", tag, k, words[k], exp_w[k]); else pass_cnt++;
        end
        total_cnt++; if (adj != 0) $display("FAIL %s_adjacent got %0d want 0", tag, adj); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [16:0] e [4];
        reset = 1'b1; tick(); reset = 1'b0; tick();
        post(0, T_RD, 4'h1, 8'h00);
        post(1, T_FL, 4'h1, 8'h55);
        post(2, T_RD, 4'h1, 8'h00);
        post(3, T_UPGR, 4'h2, 8'h00);
        e[0] = mk(0, T_DS, 4'h1, 8'h55);
        e[1] = mk(1, T_ACK, 4'h1, 8'h55);
        e[2] = mk(2, T_DE, 4'h1, 8'h55);
        e[3] = mk(3, T_ACK, 4'h2, 8'h00);
        burst(e, "burst1");
        for (int k = 0; k < 4; k++) begin
            post(k, T_RD, 4'(8 + k), 8'h00);
            e[k] = mk(k, T_DE, 4'(8 + k), 8'hff);
        end
        burst(e, "burst2");
    endtask

    task automatic test_illegal();
        int seen;
        seen = 0;
        post(1, T_NONE, 4'h3, 8'h00);
        tick();
        if (resp_flag === 1'b1) seen++;
        tick();
        if (resp_flag === 1'b1) seen++;
        req_flag[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin tick(); if (resp_flag === 1'b1) seen++; end
        total_cnt++; if (seen != 0 || busy !== 1'b0) $display("FAIL illegal_drop resp=%0d busy=%b want 0,0", seen, busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [16:0] rb;
        run_txn(0, T_FL, 4'h0, 8'h12, lat, rb);
        tick();
        post(0, T_RD, 4'h0, 8'h00);
        tick(); tick();
        reset = 1'b1;
        req_flag[0] = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0 || resp_flag !== 1'b0 || grant !== 4'b0) $display("FAIL rmid_state busy=%b flag=%b grant=%b want 0,0,0", busy, resp_flag, grant); else pass_cnt++;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin tick(); if (resp_flag === 1'b1) seen++; end
        total_cnt++; if (seen != 0) $display("FAIL rmid_no_resp got %0d want 0", seen); else pass_cnt++;
        run_txn(0, T_RD, 4'h0, 8'h00, lat, rb);
        total_cnt++; if (lat != 4 || rb !== mk(0, T_DE, 4'h0, 8'hff)) $display("FAIL rmid_mem0 got lat %0d %h want 4 %h", lat, rb, mk(0, T_DE, 4'h0, 8'hff)); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_rd();
        test_flush_then_rd();
        test_shared();
        test_snoop_flush();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
